// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from JK-style toggle stages; 1-cycle count/load latency.
// No backpressure: tc is a combinational carry-out that feeds the next stage's en.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             cl_n,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q  = '0;
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, nq_q;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] tgl;
  logic             at_max, at_zero, out_of_range;

  assign at_max       = (q_q == MAX_Q);
  assign at_zero      = (q_q == ZERO_Q);
  assign out_of_range = ({1'b0, q_q} >= MOD_EXT);

  always_comb begin
    next_val = q_q;
    ovf_d    = ovf_q;
    if (ld) begin
      next_val = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
      ovf_d    = 1'b0;
    end else if (en) begin
      // An illegal state (only reachable through X-recovery) snaps back to zero.
      if (out_of_range) begin
        next_val = ZERO_Q;
        ovf_d    = 1'b1;
      end else if (up) begin
        if (at_max) begin
          next_val = ZERO_Q;
          ovf_d    = 1'b1;
        end else begin
          next_val = q_q + ONE_Q;
        end
      end else begin
        if (at_zero) begin
          next_val = MAX_Q;
          ovf_d    = 1'b1;
        end else begin
          next_val = q_q - ONE_Q;
        end
      end
    end
  end

  // J=K=tgl[i]: each stage either holds or toggles, both rails flipping together.
  assign tgl = q_q ^ next_val;

  always_ff @(posedge clk or negedge cl_n) begin
    if (!cl_n) begin
      q_q   <= '0;
      nq_q  <= '1;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_q ^ tgl;
      nq_q  <= nq_q ^ tgl;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign nq  = nq_q;
  assign ovf = ovf_q;
  assign tc  = en & ~ld & (up ? at_max : at_zero);

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter: single decade stage plus a two-digit cascade.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       cl_n, en, up, ld, cen;
  logic [3:0] d;
  logic [3:0] q, nq, lo_q, lo_nq, hi_q, hi_nq;
  logic       tc, ovf, lo_tc, lo_ovf, hi_tc, hi_ovf;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .cl_n(cl_n), .en(en), .up(up), .ld(ld), .d(d),
    .q(q), .nq(nq), .tc(tc), .ovf(ovf)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .cl_n(cl_n), .en(cen), .up(1'b1), .ld(1'b0), .d(4'h0),
    .q(lo_q), .nq(lo_nq), .tc(lo_tc), .ovf(lo_ovf)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .cl_n(cl_n), .en(lo_tc), .up(1'b1), .ld(1'b0), .d(4'h0),
    .q(hi_q), .nq(hi_nq), .tc(hi_tc), .ovf(hi_ovf)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic eovf);
    logic [3:0] enq;
    enq = ~eq;
    chk({tag, ".q"}, 16'(q), 16'(eq));
    chk({tag, ".nq"}, 16'(nq), 16'(enq));
    chk({tag, ".ovf"}, 16'(ovf), 16'(eovf));
  endtask

  initial begin
    cl_n = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; d = 4'h0; cen = 1'b0;
    tick();
    tick();
    chk_state("reset", 4'h0, 1'b0);
    chk("reset.tc", 16'(tc), 16'h0);
    chk("reset.lo_q", 16'(lo_q), 16'h0);

    @(negedge clk);
    cl_n = 1'b1;
    tick();
    chk_state("release", 4'h0, 1'b0);

    // Up count through the wrap.
    en = 1'b1; up = 1'b1;
    #1;
    chk("up.tc0", 16'(tc), 16'h0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_state($sformatf("up%0d", i), 4'(i % 10), (i >= 10));
      chk($sformatf("up%0d.tc", i), 16'(tc), 16'((i % 10) == 9));
    end

    // Advance 2 -> 7, then clear between edges.
    repeat (5) tick();
    chk_state("pre_clr", 4'h7, 1'b1);
    #2;
    cl_n = 1'b0;
    #1;
    chk_state("clr_async", 4'h0, 1'b0);
    up = 1'b0;
    #1;
    chk("clr.tc_down", 16'(tc), 16'h1);
    en = 1'b0; up = 1'b1;
    @(negedge clk);
    cl_n = 1'b1;
    tick();
    chk_state("clr_release", 4'h0, 1'b0);

    // Down count from a loaded zero.
    ld = 1'b1; d = 4'h0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    chk("down.tc_at0", 16'(tc), 16'h1);
    tick();
    chk_state("down1", 4'h9, 1'b1);
    chk("down1.tc", 16'(tc), 16'h0);
    tick();
    chk_state("down2", 4'h8, 1'b1);
    tick();
    chk_state("down3", 4'h7, 1'b1);

    // Load priority over count, and clamping.
    ld = 1'b1; en = 1'b1; up = 1'b1; d = 4'h4;
    #1;
    chk("ld4.tc_pre", 16'(tc), 16'h0);
    tick();
    chk_state("ld4", 4'h4, 1'b0);
    chk("ld4.tc", 16'(tc), 16'h0);
    d = 4'hD;
    tick();
    chk_state("ld13", 4'h9, 1'b0);
    chk("ld13.tc", 16'(tc), 16'h0);
    d = 4'hA;
    tick();
    chk_state("ld10", 4'h9, 1'b0);
    d = 4'h5;
    tick();
    chk_state("ld5", 4'h5, 1'b0);

    // Wrap up from 9 to set ovf, then hold with up toggling.
    d = 4'h9;
    tick();
    ld = 1'b0;
    tick();
    chk_state("wrap", 4'h0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = i[0];
      tick();
      chk_state($sformatf("hold%0d", i), 4'h0, 1'b1);
      chk($sformatf("hold%0d.tc", i), 16'(tc), 16'h0);
    end

    // Two-digit cascade from 00.
    chk("cas.start", 16'({hi_q, lo_q}), 16'h00);
    cen = 1'b1;
    repeat (99) tick();
    chk("cas99.val", 16'({hi_q, lo_q}), 16'h99);
    chk("cas99.hi_tc", 16'(hi_tc), 16'h1);
    chk("cas99.ovf", 16'({hi_ovf, lo_ovf}), 16'b01);
    tick();
    chk("cas100.val", 16'({hi_q, lo_q}), 16'h00);
    chk("cas100.ovf", 16'({hi_ovf, lo_ovf}), 16'b11);
    chk("cas100.nq", 16'({hi_nq, lo_nq}), 16'hFF);
    cen = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
